// File: rtl/disp_scan_ctrl.sv
// Time-multiplexed 7-segment scan controller with double-buffered display word and dead-time guard.
// Define DISP_LZS_EN to enable leading-zero suppression of upper digits.
module disp_scan_ctrl #(
   parameter int N_DIGITS  = 4,
   parameter int SHOW_CYC  = 50000,
   parameter int GUARD_CYC = 500
) (
   input  logic                          i_clk,
   input  logic                          i_rst_n,
   input  logic                          i_enable,
   input  logic                          i_load,
   input  logic [4*N_DIGITS-1:0]         i_value,
   input  logic [N_DIGITS-1:0]           i_blank_mask,
   output logic [3:0]                    o_nibble,
   output logic [N_DIGITS-1:0]           o_anodes,
   output logic [$clog2(N_DIGITS)-1:0]   o_digit_idx,
   output logic                          o_frame_done,
   output logic                          o_pending
);

   localparam int IW      = $clog2(N_DIGITS);
   localparam int MAX_CYC = (SHOW_CYC > GUARD_CYC) ? SHOW_CYC : GUARD_CYC;
   localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;

   localparam logic [CW-1:0] GUARD_LAST = CW'(GUARD_CYC - 1);
   localparam logic [CW-1:0] SHOW_LAST  = CW'(SHOW_CYC - 1);
   localparam logic [IW-1:0] LAST_IDX   = IW'(N_DIGITS - 1);

   typedef enum logic [1:0] {IDLE, GUARD, SHOW} state_t;

   state_t                state, state_next;
   logic [CW-1:0]         cnt, cnt_next;
   logic [IW-1:0]         idx, idx_next;
   logic [4*N_DIGITS-1:0] active, active_next;
   logic [4*N_DIGITS-1:0] pend_buf, pend_buf_next;
   logic                  pend_next;
   logic                  commit;
   logic [N_DIGITS-1:0]   lz;
   logic [N_DIGITS-1:0]   anodes_next;
   logic [3:0]            nibble_next;
   logic                  done_next;
`ifdef DISP_LZS_EN
   logic                  zero_above;
`endif

   assign o_digit_idx = idx;

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state        <= IDLE;
         cnt          <= '0;
         idx          <= '0;
         active       <= '0;
         pend_buf     <= '0;
         o_pending    <= 1'b0;
         o_anodes     <= '1;
         o_nibble     <= 4'd0;
         o_frame_done <= 1'b0;
      end else begin
         state        <= state_next;
         cnt          <= cnt_next;
         idx          <= idx_next;
         active       <= active_next;
         pend_buf     <= pend_buf_next;
         o_pending    <= pend_next;
         o_anodes     <= anodes_next;
         o_nibble     <= nibble_next;
         o_frame_done <= done_next;
      end
   end

   // Commits happen on scan start and on the wrap after the last digit, so the active word is frame-stable.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      commit     = 1'b0;
      if (!i_enable) begin
         state_next = IDLE;
         cnt_next   = '0;
         idx_next   = '0;
      end else begin
         case (state)
            IDLE: begin
               state_next = GUARD;
               cnt_next   = '0;
               idx_next   = '0;
               commit     = 1'b1;
            end
            GUARD: begin
               if (cnt == GUARD_LAST) begin
                  state_next = SHOW;
                  cnt_next   = '0;
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
            SHOW: begin
               if (cnt == SHOW_LAST) begin
                  state_next = GUARD;
                  cnt_next   = '0;
                  if (idx == LAST_IDX) begin
                     idx_next = '0;
                     commit   = 1'b1;
                  end else begin
                     idx_next = idx + IW'(1);
                  end
               end else begin
                  cnt_next = cnt + CW'(1);
               end
            end
            default: begin
               state_next = IDLE;
               cnt_next   = '0;
               idx_next   = '0;
            end
         endcase
      end
   end

   // With nothing pending, pend_buf always equals active, so an unconditional commit is harmless.
   always_comb begin
      active_next   = active;
      pend_buf_next = pend_buf;
      pend_next     = o_pending;
      if (commit) begin
         active_next = i_load ? i_value : pend_buf;
         if (i_load) begin
            pend_buf_next = i_value;
         end
         pend_next = 1'b0;
      end else if (i_load) begin
         pend_buf_next = i_value;
         pend_next     = 1'b1;
      end
   end

   always_comb begin
      lz = '0;
`ifdef DISP_LZS_EN
      zero_above = 1'b1;
      for (int k = N_DIGITS - 1; k > 0; k--) begin
         zero_above = zero_above & (active_next[4*k +: 4] == 4'd0);
         lz[k]      = zero_above;
      end
`endif
   end

   // Outputs are computed from next-state values so the registered pins line up with the FSM state.
   always_comb begin
      anodes_next = '1;
      if ((state_next == SHOW) && !i_blank_mask[idx_next] && !lz[idx_next]) begin
         anodes_next[idx_next] = 1'b0;
      end
      nibble_next = active_next[{idx_next, 2'b00} +: 4];
      done_next   = (state_next == SHOW) && (idx_next == LAST_IDX) && (cnt_next == SHOW_LAST);
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// Scoreboard bench for disp_scan_ctrl: per-cycle expected scan outputs are queued as stimulus is driven
// and popped by a monitor one cycle at a time.
module tb_disp_scan_ctrl;

   localparam int N_DIGITS  = 4;
   localparam int SHOW_CYC  = 8;
   localparam int GUARD_CYC = 2;
   localparam int SLOT      = SHOW_CYC + GUARD_CYC;
   localparam int FRAME     = N_DIGITS * SLOT;
`ifdef DISP_LZS_EN
   localparam bit LZS_ON = 1'b1;
`else
   localparam bit LZS_ON = 1'b0;
`endif

   typedef struct {
      logic [3:0] anodes;
      logic [3:0] nibble;
      logic [1:0] idx;
      logic       fd;
      bit         chk;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        enable;
   logic        load;
   logic [15:0] value;
   logic [3:0]  blank_mask;
   logic [3:0]  nibble;
   logic [3:0]  anodes;
   logic [1:0]  digit_idx;
   logic        frame_done;
   logic        pending;

   exp_t exp_q[$];
   exp_t mon_e;
   bit   mon_en = 1'b0;
   int   entry = 0;
   int   t = 0;
   int   compared = 0;
   int   mismatched = 0;

   disp_scan_ctrl #(
      .N_DIGITS (N_DIGITS),
      .SHOW_CYC (SHOW_CYC),
      .GUARD_CYC(GUARD_CYC)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_enable    (enable),
      .i_load      (load),
      .i_value     (value),
      .i_blank_mask(blank_mask),
      .o_nibble    (nibble),
      .o_anodes    (anodes),
      .o_digit_idx (digit_idx),
      .o_frame_done(frame_done),
      .o_pending   (pending)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      compared++;
      if (obs !== exp) begin
         mismatched++;
         $display("[TB] FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   // Expected outputs for the first n cycles of a frame that starts with guard of digit 0.
   task automatic pushFrame(input logic [15:0] v, input logic [3:0] mask, input int n);
      exp_t e;
      int   d;
      int   r;
      bit   lz;
      for (int i = 0; i < n; i++) begin
         d        = i / SLOT;
         r        = i % SLOT;
         lz       = LZS_ON && (d > 0) && ((v >> (4 * d)) == 16'd0);
         e.idx    = 2'(d);
         e.nibble = v[4*d +: 4];
         e.anodes = ((r < GUARD_CYC) || mask[d] || lz) ? 4'hF : ~(4'b0001 << d);
         e.fd     = (i == FRAME - 1);
         e.chk    = 1'b1;
         exp_q.push_back(e);
      end
   endtask

   task automatic pushIdle(input int n);
      exp_t e;
      for (int i = 0; i < n; i++) begin
         e.idx    = 2'd0;
         e.nibble = 4'd0;
         e.anodes = 4'hF;
         e.fd     = 1'b0;
         e.chk    = 1'b0;
         exp_q.push_back(e);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
      t++;
   endtask

   task automatic runTo(input int target);
      while (t < target) tick();
   endtask

   task automatic applyStimulus(input logic [15:0] v);
      load  = 1'b1;
      value = v;
      tick();
      load  = 1'b0;
   endtask

   always @(posedge clk) begin
      #1;
      if (mon_en) begin
         if (exp_q.size() == 0) begin
            checkOutput("queue_underrun", 32'(exp_q.size()), 32'd1);
         end else begin
            mon_e = exp_q.pop_front();
            checkOutput($sformatf("anodes@%0d", entry), 32'(anodes), 32'(mon_e.anodes));
            checkOutput($sformatf("frame_done@%0d", entry), 32'(frame_done), 32'(mon_e.fd));
            if (mon_e.chk) begin
               checkOutput($sformatf("nibble@%0d", entry), 32'(nibble), 32'(mon_e.nibble));
               checkOutput($sformatf("idx@%0d", entry), 32'(digit_idx), 32'(mon_e.idx));
            end
            entry++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: got timeout, expected completion");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      rst_n      = 1'b0;
      enable     = 1'b0;
      load       = 1'b0;
      value      = 16'h0;
      blank_mask = 4'h0;
      repeat (2) @(posedge clk);
      #2;
      checkOutput("rst_anodes", 32'(anodes), 32'hF);
      checkOutput("rst_nibble", 32'(nibble), 32'h0);
      checkOutput("rst_idx", 32'(digit_idx), 32'h0);
      checkOutput("rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("rst_pending", 32'(pending), 32'h0);
      rst_n = 1'b1;
      tick();

      applyStimulus(16'h1234);
      checkOutput("pending_preload", 32'(pending), 32'h1);
      checkOutput("anodes_idle", 32'(anodes), 32'hF);

      t      = 0;
      enable = 1'b1;
      pushFrame(16'h1234, 4'h0, FRAME);
      pushFrame(16'h1234, 4'h0, FRAME);
      mon_en = 1'b1;
      tick();
      checkOutput("pending_after_start", 32'(pending), 32'h0);

      // Mid-frame load shows up only after the next frame boundary.
      runTo(56);
      pushFrame(16'hABCD, 4'h0, FRAME);
      applyStimulus(16'hABCD);
      checkOutput("pending_abcd", 32'(pending), 32'h1);
      runTo(82);
      checkOutput("pending_committed", 32'(pending), 32'h0);

      runTo(86);
      applyStimulus(16'h1111);
      checkOutput("pending_1111", 32'(pending), 32'h1);
      runTo(101);
      pushFrame(16'h2222, 4'h0, FRAME);
      applyStimulus(16'h2222);
      checkOutput("pending_2222", 32'(pending), 32'h1);

      // Load coincident with the frame_done cycle commits directly.
      runTo(160);
      pushFrame(16'h5555, 4'h0, FRAME);
      pushFrame(16'h5555, 4'b0100, FRAME);
      applyStimulus(16'h5555);
      checkOutput("pending_direct_commit", 32'(pending), 32'h0);

      runTo(200);
      blank_mask = 4'b0100;
      runTo(240);
      blank_mask = 4'b0000;
      pushFrame(16'h5555, 4'h0, 15);

      runTo(255);
      enable = 1'b0;
      pushIdle(3);
      runTo(258);
      enable = 1'b1;
      pushFrame(16'h5555, 4'h0, FRAME);

      runTo(270);
      pushFrame(16'h0070, 4'h0, FRAME);
      applyStimulus(16'h0070);
      checkOutput("pending_0070", 32'(pending), 32'h1);

      runTo(338);
      checkOutput("queue_drained", 32'(exp_q.size()), 32'h0);
      mon_en = 1'b0;

      runTo(350);
      applyStimulus(16'hFFFF);
      checkOutput("pending_ffff", 32'(pending), 32'h1);
      runTo(356);
      checkOutput("pre_rst_anodes", 32'(anodes), 32'hD);
      checkOutput("pre_rst_nibble", 32'(nibble), 32'h7);
      checkOutput("pre_rst_idx", 32'(digit_idx), 32'h1);

      // Asynchronous reset between clock edges.
      #1;
      rst_n = 1'b0;
      #1;
      checkOutput("async_rst_anodes", 32'(anodes), 32'hF);
      checkOutput("async_rst_nibble", 32'(nibble), 32'h0);
      checkOutput("async_rst_idx", 32'(digit_idx), 32'h0);
      checkOutput("async_rst_frame_done", 32'(frame_done), 32'h0);
      checkOutput("async_rst_pending", 32'(pending), 32'h0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
